game_stats: RTL and testbench
=============================

// Module: game_stats
// PURPOSE
//   Sequential game-state keeper producing every value the scoreboard renders: enemy tanks left,
//   level, both player scores, both players' lives. Consumes one-cycle event pulses from the
//   game logic (kills, hits, start) and runs the level/game-over sequence. All outputs are
//   registered and feed the scoreboard renderer directly.
// PARAMETERS
//   TANKS_PER_LEVEL  20    enemy tanks loaded at each level start (1..32)
//   START_LIVES      3     lives per player at game start (1..MAX_LIVES)
//   MAX_LIVES        9     lives saturation value (<=15)
//   MAX_LEVEL        9     last level; clearing it ends the game (1..9)
//   SCORE_MAX        1999  score saturation value (<=2047)
//   BONUS_STEP       500   each crossing of a multiple of this awards one extra life
//   CLEAR_CYCLES     120   cycles spent in CLEAR between levels (>=1)
// PORTS
//   clk_i                 in   1   clock
//   rst_i                 in   1   reset, asynchronous, active-high
//   start_i               in   1   pulse: start new game (honoured in IDLE and OVER only)
//   p1_kill_i, p2_kill_i  in   1   pulse: player destroyed one enemy tank
//   p1_kill_pts_i         in   7   points for p1 kill (0..127), valid with p1_kill_i
//   p2_kill_pts_i         in   7   points for p2 kill, valid with p2_kill_i
//   p1_hit_i, p2_hit_i    in   1   pulse: player tank destroyed
//   tank_left_o           out  6   enemy tanks remaining this level
//   level_o               out  4   current level, 1..MAX_LEVEL
//   player_1_score_o      out  11  p1 score, binary
//   player_2_score_o      out  11  p2 score, binary
//   player_1_live_left_o  out  4   p1 lives
//   player_2_live_left_o  out  4   p2 lives
//   state_o               out  2   0 IDLE, 1 PLAY, 2 CLEAR, 3 OVER
//   level_clear_o         out  1   one-cycle pulse on PLAY->CLEAR
//   game_over_o           out  1   high while in OVER
// BEHAVIOUR
//   Reset: IDLE; tank_left=TANKS_PER_LEVEL, level=1, scores=0, lives=START_LIVES, pulses 0.
//   All outputs update on the clock edge after the triggering event (1-cycle latency).
//   IDLE/OVER: start_i -> PLAY, reload: scores 0, lives START_LIVES, level 1, tanks reload.
//     All other inputs ignored.
//   PLAY, per cycle:
//   - Kill from player with lives>0 (kills from a 0-lives player ignored): score +=
//     pts, saturating at SCORE_MAX; tank_left -= 1, floor 0.
//   - Both kills same cycle: both scores add; tank_left -= 2, floor 0.
//   - Bonus: if floor(old/BONUS_STEP) < floor(new/BONUS_STEP), lives +1 (one life per
//     cycle max), saturating MAX_LIVES. Computed on the saturated new score.
//   - Hit with lives>0: lives -1. Hit + bonus same cycle: net unchanged.
//   - Next state from post-update values: both lives 0 -> OVER (takes priority);
//     else tank_left 0 -> CLEAR with level_clear_o=1 for that cycle.
//   CLEAR: down-counter loaded with CLEAR_CYCLES-1 on entry; all inputs ignored.
//     At count 0: if level<MAX_LEVEL, level+1, tank_left reload, -> PLAY;
//     else -> OVER (level stays MAX_LEVEL). Scores and lives carry over.
//   OVER: game_over_o=1; values frozen until start_i.
//   start_i outside IDLE/OVER ignored. Reset mid-game: immediate return to reset values.
//   Arithmetic: score sum at 12 bits before saturation; tank subtract at 7 bits signed.
// TESTING
//   reset, start_i -> state PLAY, tank 20, level 1, scores 0, lives 3/3.
//   p1 kills with pts 100 x5 -> score 500, lives 4 after the 5th, tank 15.
//   Same-cycle p1 kill 127 and p2 kill 50 with tank_left=1 -> tank 0, both scores
//     add, level_clear_o for 1 cycle, CLEAR; after 120 cycles level 2, tank 20, PLAY.
//   p1 at 1950 kills 127 -> score 1999 saturated; 1999 again + kill -> stays 1999.
//   p2 hit with 1 life, p1 at 0 -> both 0 -> OVER; start_i -> fresh PLAY.
//   p1 hit 3x -> lives 0; later p1 kills ignored, p2 kills still count.

Source files
------------

// File: rtl/game_stats.sv
// Scoreboard state keeper for the game: tracks tanks, level, scores and lives,
// and runs the IDLE -> PLAY -> CLEAR -> OVER sequence from one-cycle game events.
module game_stats #(
  parameter int TANKS_PER_LEVEL = 20,
  parameter int START_LIVES     = 3,
  parameter int MAX_LIVES       = 9,
  parameter int MAX_LEVEL       = 9,
  parameter int SCORE_MAX       = 1999,
  parameter int BONUS_STEP      = 500,
  parameter int CLEAR_CYCLES    = 120
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        p1_kill_i,
  input  logic        p2_kill_i,
  input  logic [6:0]  p1_kill_pts_i,
  input  logic [6:0]  p2_kill_pts_i,
  input  logic        p1_hit_i,
  input  logic        p2_hit_i,
  output logic [5:0]  tank_left_o,
  output logic [3:0]  level_o,
  output logic [10:0] player_1_score_o,
  output logic [10:0] player_2_score_o,
  output logic [3:0]  player_1_live_left_o,
  output logic [3:0]  player_2_live_left_o,
  output logic [1:0]  state_o,
  output logic        level_clear_o,
  output logic        game_over_o
);

  // state | meaning
  // IDLE  | after reset, waiting for start
  // PLAY  | level in progress, events update stats
  // CLEAR | pause between levels, counter runs down
  // OVER  | game finished, stats frozen until start
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLAY  = 2'd1,
    S_CLEAR = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  localparam int CW = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
  localparam logic [CW-1:0] CLR_LOAD     = CW'(CLEAR_CYCLES - 1);
  localparam logic [11:0]   SCORE_MAX_12 = 12'(SCORE_MAX);
  localparam logic [5:0]    TANK_LOAD    = 6'(TANKS_PER_LEVEL);
  localparam logic [3:0]    LIVES_LOAD   = 4'(START_LIVES);
  localparam logic [3:0]    LIVES_MAX_4  = 4'(MAX_LIVES);
  localparam logic [3:0]    LEVEL_LAST   = 4'(MAX_LEVEL);

  state_t state, state_nxt;

  logic [CW-1:0] clr_cnt, clr_cnt_nxt;
  logic [5:0]    tank_nxt;
  logic [3:0]    level_nxt;
  logic [10:0]   score1_nxt, score2_nxt;
  logic [3:0]    lives1_nxt, lives2_nxt;
  logic          level_clear_nxt;

  logic          p1_ok, p2_ok, p1_hit_ok, p2_hit_ok, p1_bonus, p2_bonus;
  logic [11:0]   p1_sum, p2_sum;
  logic [10:0]   p1_new, p2_new;
  logic [3:0]    p1_lives_new, p2_lives_new;
  logic [6:0]    kills;
  logic signed [6:0] tank_diff;
  logic [5:0]    tank_new;

  // Number of BONUS_STEP multiples at or below a score; a change marks a crossing.
  function automatic int bonus_bucket(input logic [10:0] s);
    int n;
    n = 0;
    for (int k = 1; k * BONUS_STEP <= 2047; k++) begin
      if (int'(s) >= k * BONUS_STEP) n = n + 1;
    end
    return n;
  endfunction

  function automatic logic [3:0] lives_update(input logic [3:0] l, input logic bonus,
                                              input logic hit);
    logic [3:0] r;
    r = l;
    case ({bonus, hit})
      2'b10:   r = (l >= LIVES_MAX_4) ? LIVES_MAX_4 : l + 4'd1;
      2'b01:   r = l - 4'd1;
      default: r = l;
    endcase
    return r;
  endfunction

  always_comb begin : play_math
    p1_ok     = p1_kill_i && (player_1_live_left_o != 4'd0);
    p2_ok     = p2_kill_i && (player_2_live_left_o != 4'd0);
    p1_hit_ok = p1_hit_i && (player_1_live_left_o != 4'd0);
    p2_hit_ok = p2_hit_i && (player_2_live_left_o != 4'd0);

    p1_sum = {1'b0, player_1_score_o} + {5'd0, p1_kill_pts_i};
    p2_sum = {1'b0, player_2_score_o} + {5'd0, p2_kill_pts_i};

    if (!p1_ok)                     p1_new = player_1_score_o;
    else if (p1_sum > SCORE_MAX_12) p1_new = SCORE_MAX_12[10:0];
    else                            p1_new = p1_sum[10:0];

    if (!p2_ok)                     p2_new = player_2_score_o;
    else if (p2_sum > SCORE_MAX_12) p2_new = SCORE_MAX_12[10:0];
    else                            p2_new = p2_sum[10:0];

    p1_bonus = p1_ok && (bonus_bucket(player_1_score_o) < bonus_bucket(p1_new));
    p2_bonus = p2_ok && (bonus_bucket(player_2_score_o) < bonus_bucket(p2_new));

    p1_lives_new = lives_update(player_1_live_left_o, p1_bonus, p1_hit_ok);
    p2_lives_new = lives_update(player_2_live_left_o, p2_bonus, p2_hit_ok);

    kills     = {6'd0, p1_ok} + {6'd0, p2_ok};
    tank_diff = $signed({1'b0, tank_left_o}) - $signed(kills);
    tank_new  = tank_diff[6] ? 6'd0 : tank_diff[5:0];
  end

  always_comb begin : fsm_next
    state_nxt       = state;
    clr_cnt_nxt     = clr_cnt;
    tank_nxt        = tank_left_o;
    level_nxt       = level_o;
    score1_nxt      = player_1_score_o;
    score2_nxt      = player_2_score_o;
    lives1_nxt      = player_1_live_left_o;
    lives2_nxt      = player_2_live_left_o;
    level_clear_nxt = 1'b0;

    case (state)
      S_IDLE, S_OVER: begin
        if (start_i) begin
          state_nxt  = S_PLAY;
          tank_nxt   = TANK_LOAD;
          level_nxt  = 4'd1;
          score1_nxt = 11'd0;
          score2_nxt = 11'd0;
          lives1_nxt = LIVES_LOAD;
          lives2_nxt = LIVES_LOAD;
        end
      end
      S_PLAY: begin
        tank_nxt   = tank_new;
        score1_nxt = p1_new;
        score2_nxt = p2_new;
        lives1_nxt = p1_lives_new;
        lives2_nxt = p2_lives_new;
        // Losing the last life wins over clearing the level on the same cycle.
        if (p1_lives_new == 4'd0 && p2_lives_new == 4'd0) begin
          state_nxt = S_OVER;
        end else if (tank_new == 6'd0) begin
          state_nxt       = S_CLEAR;
          clr_cnt_nxt     = CLR_LOAD;
          level_clear_nxt = 1'b1;
        end
      end
      S_CLEAR: begin
        if (clr_cnt == '0) begin
          if (level_o < LEVEL_LAST) begin
            state_nxt = S_PLAY;
            level_nxt = level_o + 4'd1;
            tank_nxt  = TANK_LOAD;
          end else begin
            state_nxt = S_OVER;
          end
        end else begin
          clr_cnt_nxt = clr_cnt - 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      clr_cnt              <= '0;
      tank_left_o          <= TANK_LOAD;
      level_o              <= 4'd1;
      player_1_score_o     <= 11'd0;
      player_2_score_o     <= 11'd0;
      player_1_live_left_o <= LIVES_LOAD;
      player_2_live_left_o <= LIVES_LOAD;
      level_clear_o        <= 1'b0;
      game_over_o          <= 1'b0;
    end else begin
      clr_cnt              <= clr_cnt_nxt;
      tank_left_o          <= tank_nxt;
      level_o              <= level_nxt;
      player_1_score_o     <= score1_nxt;
      player_2_score_o     <= score2_nxt;
      player_1_live_left_o <= lives1_nxt;
      player_2_live_left_o <= lives2_nxt;
      level_clear_o        <= level_clear_nxt;
      game_over_o          <= (state_nxt == S_OVER);
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_game_stats.sv
// Bench for game_stats: directed game scenarios followed by random play, every
// cycle compared against an arithmetic model of the scoring and level rules.
module tb_game_stats;

  localparam int TPL = 20, SL = 3, ML = 9, MLV = 9, SMAX = 1999, BSTEP = 500, CLRC = 120;

  logic        clk_sys = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, k1 = 1'b0, k2 = 1'b0, h1 = 1'b0, h2 = 1'b0;
  logic [6:0]  pts1 = '0, pts2 = '0;
  logic [5:0]  tank_left;
  logic [3:0]  level, lives1, lives2;
  logic [10:0] score1, score2;
  logic [1:0]  state;
  logic        level_clear, game_over;

  game_stats dut (
    .clk_i(clk_sys), .rst_i(rst), .start_i(start),
    .p1_kill_i(k1), .p2_kill_i(k2), .p1_kill_pts_i(pts1), .p2_kill_pts_i(pts2),
    .p1_hit_i(h1), .p2_hit_i(h2),
    .tank_left_o(tank_left), .level_o(level),
    .player_1_score_o(score1), .player_2_score_o(score2),
    .player_1_live_left_o(lives1), .player_2_live_left_o(lives2),
    .state_o(state), .level_clear_o(level_clear), .game_over_o(game_over)
  );

  always #5 clk_sys = ~clk_sys;

  int n_checks = 0, n_fail = 0;
  // model: 0 idle, 1 play, 2 clear, 3 over
  int m_state, m_tank, m_level, m_s1, m_s2, m_l1, m_l2, m_clr, m_lc, m_go;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_tank = TPL; m_level = 1; m_s1 = 0; m_s2 = 0;
    m_l1 = SL; m_l2 = SL; m_clr = 0; m_lc = 0; m_go = 0;
  endtask

  task automatic model_step(input int st, input int a1, input int p1, input int a2,
                            input int p2, input int x1, input int x2);
    int ok1, ok2, ns1, ns2, nl1, nl2, nt, b1, b2;
    m_lc = 0;
    case (m_state)
      0, 3: if (st != 0) begin
        m_state = 1; m_tank = TPL; m_level = 1; m_s1 = 0; m_s2 = 0; m_l1 = SL; m_l2 = SL;
      end
      1: begin
        ok1 = (a1 != 0 && m_l1 > 0) ? 1 : 0;
        ok2 = (a2 != 0 && m_l2 > 0) ? 1 : 0;
        ns1 = ok1 ? ((m_s1 + p1 > SMAX) ? SMAX : m_s1 + p1) : m_s1;
        ns2 = ok2 ? ((m_s2 + p2 > SMAX) ? SMAX : m_s2 + p2) : m_s2;
        b1 = (ns1 / BSTEP > m_s1 / BSTEP) ? 1 : 0;
        b2 = (ns2 / BSTEP > m_s2 / BSTEP) ? 1 : 0;
        nl1 = m_l1 + b1 - ((x1 != 0 && m_l1 > 0) ? 1 : 0);
        nl2 = m_l2 + b2 - ((x2 != 0 && m_l2 > 0) ? 1 : 0);
        if (nl1 > ML) nl1 = ML;
        if (nl2 > ML) nl2 = ML;
        nt = m_tank - ok1 - ok2;
        if (nt < 0) nt = 0;
        m_s1 = ns1; m_s2 = ns2; m_l1 = nl1; m_l2 = nl2; m_tank = nt;
        if (nl1 == 0 && nl2 == 0) m_state = 3;
        else if (nt == 0) begin m_state = 2; m_lc = 1; m_clr = 0; end
      end
      2: begin
        m_clr++;
        if (m_clr == CLRC) begin
          if (m_level < MLV) begin m_level++; m_tank = TPL; m_state = 1; end
          else m_state = 3;
        end
      end
      default: ;
    endcase
    m_go = (m_state == 3) ? 1 : 0;
  endtask

  task automatic check_all();
    chk("tank_left", tank_left, m_tank);
    chk("level", level, m_level);
    chk("score1", score1, m_s1);
    chk("score2", score2, m_s2);
    chk("lives1", lives1, m_l1);
    chk("lives2", lives2, m_l2);
    chk("state", state, m_state);
    chk("level_clear", level_clear, m_lc);
    chk("game_over", game_over, m_go);
  endtask

  // one clock: drive, advance model, sample 1 time unit after the edge
  task automatic cyc(input int st, input int a1, input int p1, input int a2,
                     input int p2, input int x1, input int x2);
    start = st[0]; k1 = a1[0]; pts1 = 7'(p1); k2 = a2[0]; pts2 = 7'(p2);
    h1 = x1[0]; h2 = x2[0];
    model_step(st, a1, p1, a2, p2, x1, x2);
    @(posedge clk_sys); #1;
    start = 0; k1 = 0; k2 = 0; h1 = 0; h2 = 0; pts1 = '0; pts2 = '0;
    check_all();
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk_sys);
    #1;
    check_all();
    chk("rst_state", state, 0);
    rst = 0;

    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("start_state", state, 1);
    chk("start_tank", tank_left, 20);
    chk("start_lives2", lives2, 3);

    for (int i = 0; i < 5; i++) cyc(0, 1, 100, 0, 0, 0, 0);
    chk("dir_score500", score1, 500);
    chk("dir_lives4", lives1, 4);
    chk("dir_tank15", tank_left, 15);

    for (int i = 0; i < 14; i++) cyc(0, 1, 0, 0, 0, 0, 0);
    chk("dir_tank1", tank_left, 1);
    cyc(0, 1, 127, 1, 50, 0, 0);
    chk("dir_clear_pulse", level_clear, 1);
    chk("dir_clear_state", state, 2);
    chk("dir_tank0", tank_left, 0);
    chk("dir_sc1_627", score1, 627);
    chk("dir_sc2_50", score2, 50);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("dir_pulse_gone", level_clear, 0);
    for (int i = 0; i < CLRC - 2; i++) cyc(1, 1, 9, 1, 9, 1, 1);
    chk("dir_clear_hold", state, 2);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("dir_level2", level, 2);
    chk("dir_tank20", tank_left, 20);
    chk("dir_play2", state, 1);

    for (int i = 0; i < 10; i++) cyc(0, 1, 127, 0, 0, 0, 0);
    cyc(0, 1, 53, 0, 0, 0, 0);
    chk("dir_sc1950", score1, 1950);
    cyc(0, 1, 127, 0, 0, 0, 0);
    chk("dir_sat1999", score1, 1999);
    cyc(0, 1, 10, 0, 0, 0, 0);
    chk("dir_sat_hold", score1, 1999);

    for (int i = 0; i < 16 && m_l1 > 0; i++) cyc(0, 0, 0, 0, 0, 1, 0);
    chk("dir_p1_dead", lives1, 0);
    cyc(0, 1, 100, 0, 0, 0, 0);
    chk("dir_p1_kill_ign", tank_left, 7);
    cyc(0, 1, 100, 1, 20, 0, 0);
    chk("dir_p2_kill", score2, 70);
    chk("dir_p2_tank", tank_left, 6);

    for (int i = 0; i < 16 && m_l2 > 1; i++) cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("dir_over", state, 3);
    chk("dir_over_flag", game_over, 1);
    cyc(0, 1, 50, 1, 50, 1, 1);
    chk("dir_frozen", score2, 70);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("dir_restart", state, 1);
    chk("dir_restart_sc", score1, 0);
    chk("dir_restart_l1", lives1, 3);

    for (int i = 0; i < 8000; i++) begin
      if ($urandom_range(999) == 0) begin
        rst = 1; #1;
        model_reset();
        check_all();
        @(posedge clk_sys); #1;
        check_all();
        rst = 0;
      end else begin
        cyc(($urandom_range(19) == 0) ? 1 : 0,
            ($urandom_range(99) < 40) ? 1 : 0, int'($urandom_range(127)),
            ($urandom_range(99) < 40) ? 1 : 0, int'($urandom_range(127)),
            ($urandom_range(99) == 0) ? 1 : 0, ($urandom_range(99) == 0) ? 1 : 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
